// File: rtl/arith_pkg.sv
// Shared arithmetic types and widths for the ALU datapath slices.
package arith_pkg;

  localparam int unsigned W    = 64;
  localparam int unsigned HALF = 32;

  typedef logic [63:0] word_t;
  typedef logic [31:0] half_t;

endpackage

// File: rtl/rca_32.sv
// 32-bit ripple-carry adder slice: {cout, sum} = a + b + cin.
module rca_32
  import arith_pkg::*;
(
  input  half_t a,
  input  half_t b,
  input  logic  cin,
  output half_t sum,
  output logic  cout
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < HALF; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/sub_pipe_64.sv
// Two-stage 64-bit subtractor (A - B) with valid/ready on both sides, borrow and signed overflow.
module sub_pipe_64
  import arith_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  word_t A,
  input  word_t B,
  output logic  out_valid,
  input  logic  out_ready,
  output word_t DIFF,
  output logic  BORROW,
  output logic  OVF
);

  if (W != 64) begin : g_width_check
    $error("sub_pipe_64 only supports W == 64");
  end

  logic  s1_valid;
  half_t lo_diff;
  logic  c32;
  half_t a_hi;
  half_t nb_hi;
  logic  a63;
  logic  b63;

  logic  s2_ready;
  logic  accept;
  logic  advance;

  half_t b_inv_lo;
  half_t lo_sum;
  logic  lo_cout;
  half_t hi_sum;
  logic  hi_cout;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && s2_ready;

  // Two's-complement subtraction: A + ~B + 1, carry-in of 1 on the low half.
  assign b_inv_lo = ~B[HALF-1:0];

  rca_32 u_lo (
    .a    (A[HALF-1:0]),
    .b    (b_inv_lo),
    .cin  (1'b1),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  rca_32 u_hi (
    .a    (a_hi),
    .b    (nb_hi),
    .cin  (c32),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      lo_diff  <= '0;
      c32      <= 1'b0;
      a_hi     <= '0;
      nb_hi    <= '0;
      a63      <= 1'b0;
      b63      <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      lo_diff  <= lo_sum;
      c32      <= lo_cout;
      a_hi     <= A[W-1:HALF];
      nb_hi    <= ~B[W-1:HALF];
      a63      <= A[W-1];
      b63      <= B[W-1];
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Output registers only load on advance, so they hold steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      DIFF      <= '0;
      BORROW    <= 1'b0;
      OVF       <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      DIFF      <= {hi_sum, lo_diff};
      BORROW    <= ~hi_cout;
      OVF       <= (a63 != b63) && (hi_sum[HALF-1] != a63);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub_pipe_64.sv
// Randomised self-checking bench for sub_pipe_64 against an A-B reference with an in-order scoreboard.
module tb_sub_pipe_64;
  import arith_pkg::*;

  typedef struct {
    word_t d;
    logic  br;
    logic  ov;
  } res_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  logic  in_ready;
  word_t a_in = '0;
  word_t b_in = '0;
  logic  out_valid;
  logic  out_ready = 1'b0;
  word_t diff;
  logic  borrow;
  logic  ovf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Occupancy of the two pipeline slots and the in-order list of expected results.
  logic m1v = 1'b0;
  logic m2v = 1'b0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  sub_pipe_64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DIFF      (diff),
    .BORROW    (borrow),
    .OVF       (ovf)
  );

  function automatic res_t ref_sub(input word_t a, input word_t b);
    res_t r;
    logic signed [64:0] s;
    r.d  = a - b;
    r.br = (a < b);
    s    = $signed({a[63], a}) - $signed({b[63], b});
    r.ov = (s[64] != s[63]);
    return r;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    case ($urandom_range(0, 5))
      0: w = '0;
      1: w = '1;
      2: w = 64'h8000_0000_0000_0000;
      3: w = 64'h7FFF_FFFF_FFFF_FFFF;
      4: w = {32'($urandom), 32'hFFFF_FFFF};
      default: w = {32'($urandom), 32'($urandom)};
    endcase
    return w;
  endfunction

  // One clock: drive inputs, check in_ready, step the model, then check outputs after the edge.
  task automatic cycle(input logic iv, input word_t a, input word_t b, input logic ordy,
                       output logic acc);
    logic exp_rdy;
    logic s2r;
    logic adv;
    in_valid  = iv;
    a_in      = a;
    b_in      = b;
    out_ready = ordy;
    #1;
    s2r     = !m2v || ordy;
    exp_rdy = !m1v || s2r;
    adv     = m1v && s2r;
    acc     = iv && exp_rdy;
    n_vec++;
    if (in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
    end
    if (m2v && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(ref_sub(a, b));
    m2v = adv ? 1'b1 : (ordy ? 1'b0 : m2v);
    m1v = acc ? 1'b1 : (adv ? 1'b0 : m1v);
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== m2v) begin
      n_err++;
      $display("FAIL out_valid: got %b want %b at %0t", out_valid, m2v, $time);
    end
    if (m2v) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: result shown with nothing expected at %0t", $time);
      end else if (diff !== exp_q[0].d || borrow !== exp_q[0].br || ovf !== exp_q[0].ov) begin
        n_err++;
        $display("FAIL result: got %h b%b o%b want %h b%b o%b at %0t", diff, borrow, ovf,
                 exp_q[0].d, exp_q[0].br, exp_q[0].ov, $time);
      end
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, acc);
  endtask

  task automatic test_reset();
    logic acc;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || borrow !== 1'b0 ||
        ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: ov=%b ir=%b d=%h b=%b o=%b", out_valid, in_ready, diff,
               borrow, ovf);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, acc);
  endtask

  task automatic test_basic();
    logic acc;
    cycle(1'b1, 64'd5, 64'd3, 1'b1, acc);
    n_vec++;
    if (acc !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_latency1: acc=%b out_valid=%b want 1/0", acc, out_valid);
    end
    cycle(1'b0, '0, '0, 1'b1, acc);
    n_vec++;
    if (out_valid !== 1'b1 || diff !== 64'd2 || borrow !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL basic_5m3: v=%b d=%h b=%b o=%b want 1 2 0 0", out_valid, diff, borrow, ovf);
    end
    drain();
  endtask

  task automatic test_borrow();
    logic acc;
    cycle(1'b1, 64'd0, 64'd1, 1'b1, acc);
    cycle(1'b1, 64'h0000_0001_0000_0000, 64'd1, 1'b1, acc);
    n_vec++;
    if (diff !== 64'hFFFF_FFFF_FFFF_FFFF || borrow !== 1'b1 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL borrow_0m1: d=%h b=%b o=%b want all-ones 1 0", diff, borrow, ovf);
    end
    cycle(1'b0, '0, '0, 1'b1, acc);
    n_vec++;
    if (diff !== 64'h0000_0000_FFFF_FFFF || borrow !== 1'b0) begin
      n_err++;
      $display("FAIL cross_half: d=%h b=%b want 00000000ffffffff 0", diff, borrow);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic acc;
    cycle(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, acc);
    cycle(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, acc);
    n_vec++;
    if (diff !== 64'h7FFF_FFFF_FFFF_FFFF || ovf !== 1'b1 || borrow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_neg: d=%h o=%b b=%b want 7fff.. 1 0", diff, ovf, borrow);
    end
    cycle(1'b0, '0, '0, 1'b1, acc);
    n_vec++;
    if (diff !== 64'h8000_0000_0000_0000 || ovf !== 1'b1 || borrow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_pos: d=%h o=%b b=%b want 8000.. 1 1", diff, ovf, borrow);
    end
    drain();
  endtask

  task automatic test_backpressure();
    word_t ops_a[4];
    word_t ops_b[4];
    int    nxt = 0;
    int    guard = 0;
    int    streak = 0;
    logic  acc;
    res_t  r0;
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = rand_word();
      ops_b[i] = rand_word();
    end
    r0 = ref_sub(ops_a[0], ops_b[0]);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, ops_a[nxt], ops_b[nxt], 1'b0, acc);
      if (acc) nxt++;
    end
    #1;
    n_vec++;
    if (nxt != 2 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: accepted %0d in_ready=%b want 2 0", nxt, in_ready);
    end
    n_vec++;
    if (diff !== r0.d || borrow !== r0.br || ovf !== r0.ov) begin
      n_err++;
      $display("FAIL bp_hold: d=%h want %h", diff, r0.d);
    end
    while (nxt < 4 && guard < 20) begin
      cycle(1'b1, ops_a[nxt], ops_b[nxt], 1'b1, acc);
      if (acc) nxt++;
      guard++;
    end
    n_vec++;
    if (nxt != 4) begin
      n_err++;
      $display("FAIL bp_resume: accepted %0d want 4", nxt);
    end
    drain();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, rand_word(), rand_word(), 1'b1, acc);
      if (out_valid === 1'b1) streak++;
    end
    n_vec++;
    if (streak != 5) begin
      n_err++;
      $display("FAIL back_to_back: valid cycles %0d want 5", streak);
    end
    drain();
  endtask

  task automatic test_reset_flight();
    logic acc;
    cycle(1'b1, rand_word(), rand_word(), 1'b0, acc);
    cycle(1'b1, rand_word(), rand_word(), 1'b0, acc);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0) begin
      n_err++;
      $display("FAIL reset_flight: ov=%b ir=%b d=%h want 0 1 0", out_valid, in_ready, diff);
    end
    m1v = 1'b0;
    m2v = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 64'd100, 64'd42, 1'b1, acc);
    n_vec++;
    if (acc !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_accept: acc=%b want 1", acc);
    end
    cycle(1'b0, '0, '0, 1'b1, acc);
    n_vec++;
    if (out_valid !== 1'b1 || diff !== 64'd58) begin
      n_err++;
      $display("FAIL reset_own_result: v=%b d=%h want 1 3a", out_valid, diff);
    end
    cycle(1'b0, '0, '0, 1'b1, acc);
    drain();
  endtask

  task automatic test_random();
    int   done = 0;
    int   cyc = 0;
    logic acc;
    while (done < 10000 && cyc < 60000) begin
      cycle($urandom_range(0, 9) < 7, rand_word(), rand_word(), $urandom_range(0, 9) < 7, acc);
      if (acc) done++;
      cyc++;
    end
    n_vec++;
    if (done < 10000) begin
      n_err++;
      $display("FAIL random_budget: accepted %0d want 10000", done);
    end
    drain();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: %0d results left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_backpressure();
    test_reset_flight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
